// File: rtl/uart_pkg.sv
// Shared UART definitions: the default byte width and the TX arbiter state encoding.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot winner found by searching upward from ptr+1
// with wrap-around.
module rr_pick #(
    parameter int NUM_REQ_P = 2,
    localparam int PTR_W = $clog2(NUM_REQ_P)
) (
    input  logic [NUM_REQ_P-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_REQ_P-1:0] winner,
    output logic                 found
);

    // The first pass covers indices above ptr, the second wraps around to 0..ptr.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ_P; i++) begin
            if (!found && req[i] && (i > int'(ptr))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ_P; i++) begin
            if (!found && req[i] && (i <= int'(ptr))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter that shares one uart_tx byte stream between several sources.
// The owner keeps the grant until its last byte is accepted or it goes idle for TIMEOUT_P cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH_P = UART_DATA_WIDTH,
    parameter int NUM_REQ_P    = 2,
    parameter int TIMEOUT_P    = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ_P-1:0]              req_valid_i,
    input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0] req_data_i,
    input  logic [NUM_REQ_P-1:0]              req_last_i,
    output logic [NUM_REQ_P-1:0]              req_ready_o,
    output logic [DATA_WIDTH_P-1:0]           m_data_o,
    output logic                              m_valid_o,
    input  logic                              m_ready_i,
    output logic [NUM_REQ_P-1:0]              gnt_o,
    output logic                              busy_o,
    output logic                              timeout_o
);

    localparam int PTR_W = $clog2(NUM_REQ_P);
    localparam int CNT_W = $clog2(TIMEOUT_P + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_P - 1);

    arb_state_e              state_reg;
    logic [NUM_REQ_P-1:0]    gnt_reg;
    logic [PTR_W-1:0]        ptr_reg;
    logic [CNT_W-1:0]        idle_cnt_reg;
    logic                    timeout_reg;

    logic [NUM_REQ_P-1:0]    winner;
    logic                    found;
    logic [DATA_WIDTH_P-1:0] data_masked [NUM_REQ_P];
    logic [DATA_WIDTH_P-1:0] data_mux;
    logic [PTR_W-1:0]        owner_idx;
    logic                    owner_valid;
    logic                    owner_last;
    logic                    xfer_hs;

    rr_pick #(
        .NUM_REQ_P(NUM_REQ_P)
    ) u_rr_pick (
        .req    (req_valid_i),
        .ptr    (ptr_reg),
        .winner (winner),
        .found  (found)
    );

    // gnt_reg is non-zero only in XFER, so it alone steers the passthrough.
    // rst_i gates the handshake so no byte is taken in the reset cycle.
    generate
        for (genvar gi = 0; gi < NUM_REQ_P; gi++) begin : g_req
            assign data_masked[gi] = gnt_reg[gi] ? req_data_i[gi*DATA_WIDTH_P +: DATA_WIDTH_P] : '0;
            assign req_ready_o[gi] = gnt_reg[gi] & m_ready_i & ~rst_i;
        end
    endgenerate

    always_comb begin
        data_mux  = '0;
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ_P; i++) begin
            data_mux = data_mux | data_masked[i];
            if (gnt_reg[i]) begin
                owner_idx = PTR_W'(i);
            end
        end
    end

    assign owner_valid = |(req_valid_i & gnt_reg);
    assign owner_last  = |(req_last_i & gnt_reg);
    assign m_valid_o   = owner_valid & ~rst_i;
    assign m_data_o    = rst_i ? '0 : data_mux;
    assign xfer_hs     = m_valid_o & m_ready_i;
    assign gnt_o       = gnt_reg;
    assign busy_o      = (state_reg == XFER);
    assign timeout_o   = timeout_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            ptr_reg      <= PTR_W'(NUM_REQ_P - 1);
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        state_reg    <= XFER;
                        gnt_reg      <= winner;
                        idle_cnt_reg <= '0;
                    end
                end
                XFER: begin
                    if (xfer_hs) begin
                        idle_cnt_reg <= '0;
                        if (owner_last) begin
                            state_reg <= IDLE;
                            gnt_reg   <= '0;
                            ptr_reg   <= owner_idx;
                        end
                    end else if (!owner_valid) begin
                        // A stalled-but-valid owner is backpressure and never counts as idle.
                        if (idle_cnt_reg >= CNT_LIMIT) begin
                            state_reg    <= IDLE;
                            gnt_reg      <= '0;
                            ptr_reg      <= owner_idx;
                            idle_cnt_reg <= '0;
                            timeout_reg  <= 1'b1;
                        end else begin
                            idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter with 4 requesters and a 16-cycle idle timeout.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  gnt;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad = 0;

    // Requester model state: next sequence number, bytes left in packet, packets left.
    int  seq [4];
    int  left [4];
    int  pkts [4];
    int  gen_total [4];
    bit  rand_mode = 1'b0;

    uart_tx_arbiter #(
        .DATA_WIDTH_P (8),
        .NUM_REQ_P    (4),
        .TIMEOUT_P    (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .m_data_o    (m_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .gnt_o       (gnt),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]      = v;
        req_data[i*8 +: 8] = d;
        req_last[i]       = l;
    endtask

    task automatic model_init(input int npk);
        for (int i = 0; i < 4; i++) begin
            seq[i]       = 0;
            left[i]      = 0;
            pkts[i]      = npk;
            gen_total[i] = 0;
        end
    endtask

    task automatic drive_reqs;
        for (int i = 0; i < 4; i++) begin
            if (left[i] == 0 && pkts[i] > 0) begin
                left[i]      = rand_mode ? int'($urandom_range(1, 4)) : 2;
                pkts[i]      = pkts[i] - 1;
                gen_total[i] = gen_total[i] + left[i];
            end
            if (left[i] > 0) begin
                if (!req_valid[i]) begin
                    req_valid[i] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                req_data[i*8 +: 8] = 8'((i << 6) | (seq[i] & 63));
                req_last[i]        = (left[i] == 1);
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic advance(input logic [3:0] acc);
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                seq[i]       = seq[i] + 1;
                left[i]      = left[i] - 1;
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        m_ready = 1'b0;
        repeat (3) tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%h want=00", m_data); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single;
        logic [7:0] b [3];
        b = '{8'hA1, 8'hA2, 8'hA3};
        m_ready = 1'b1;
        set_req(0, 1'b1, b[0], 1'b0);
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_arb_latency got=%b want=0000", gnt); end
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", gnt); end
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, b[k], k == 2);
            #1;
            total++;
            if (m_valid !== 1'b1 || m_data !== b[k] || req_ready !== 4'b0001) begin
                bad++;
                $display("FAIL single_byte%0d got=v%b d%h r%b want=v1 d%h r0001", k, m_valid, m_data, req_ready, b[k]);
            end
            tick();
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_release got=g%b b%b want=g0000 b0", gnt, busy); end
        $display("test_single done");
    endtask

    task automatic test_round_robin;
        logic [8:0] exp_tab [12];
        logic [3:0] acc;
        exp_tab = '{9'h000, 9'h100, 9'h101, 9'h000, 9'h140, 9'h141,
                    9'h000, 9'h102, 9'h103, 9'h000, 9'h142, 9'h143};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rand_mode = 1'b0;
        model_init(0);
        pkts[0] = 2;
        pkts[1] = 2;
        m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drive_reqs();
            #1;
            total++;
            if (m_valid !== exp_tab[c][8]) begin
                bad++;
                $display("FAIL rr_valid_c%0d got=%b want=%b", c, m_valid, exp_tab[c][8]);
            end
            if (exp_tab[c][8]) begin
                total++;
                if (m_data !== exp_tab[c][7:0]) begin
                    bad++;
                    $display("FAIL rr_data_c%0d got=%h want=%h", c, m_data, exp_tab[c][7:0]);
                end
            end
            acc = req_valid & req_ready;
            tick();
            advance(acc);
        end
        req_valid = '0;
        req_last = '0;
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure;
        int stall_errs = 0;
        m_ready = 1'b1;
        set_req(1, 1'b1, 8'hB1, 1'b0);
        tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL bp_gnt got=%b want=0010", gnt); end
        total++; if (m_data !== 8'hB1) begin bad++; $display("FAIL bp_b1 got=%h want=b1", m_data); end
        tick();
        set_req(1, 1'b1, 8'hB2, 1'b0);
        m_ready = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            #1;
            if (timeout !== 1'b0 || gnt !== 4'b0010 || m_data !== 8'hB2) stall_errs++;
            tick();
        end
        total++; if (stall_errs !== 0) begin bad++; $display("FAIL bp_stall got=%0d bad_cycles want=0", stall_errs); end
        m_ready = 1'b1;
        #1;
        total++; if (m_data !== 8'hB2 || req_ready !== 4'b0010) begin bad++; $display("FAIL bp_b2 got=d%h r%b want=db2 r0010", m_data, req_ready); end
        tick();
        set_req(1, 1'b1, 8'hB3, 1'b1);
        #1;
        total++; if (m_data !== 8'hB3 || m_valid !== 1'b1) begin bad++; $display("FAIL bp_b3 got=d%h v%b want=db3 v1", m_data, m_valid); end
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1;
        total++; if (busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL bp_end got=b%b t%b want=b0 t0", busy, timeout); end
        $display("test_backpressure done");
    endtask

    task automatic test_timeout;
        int early = 0;
        m_ready = 1'b1;
        set_req(0, 1'b1, 8'hC1, 1'b0);
        set_req(1, 1'b1, 8'hD1, 1'b1);
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL to_gnt0 got=%b want=0001", gnt); end
        total++; if (m_data !== 8'hC1) begin bad++; $display("FAIL to_c1 got=%h want=c1", m_data); end
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) begin
            #1;
            if (timeout !== 1'b0 || gnt !== 4'b0001) early++;
            tick();
        end
        total++; if (early !== 0) begin bad++; $display("FAIL to_early got=%0d bad_cycles want=0", early); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", timeout); end
        total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL to_release got=g%b b%b want=g0000 b0", gnt, busy); end
        tick();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_width got=%b want=0", timeout); end
        total++; if (gnt !== 4'b0010 || m_data !== 8'hD1) begin bad++; $display("FAIL to_next_owner got=g%b d%h want=g0010 dd1", gnt, m_data); end
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_end got=%b want=0", busy); end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_packet;
        m_ready = 1'b1;
        set_req(0, 1'b1, 8'hE1, 1'b0);
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rmp_gnt got=%b want=0001", gnt); end
        total++; if (m_data !== 8'hE1) begin bad++; $display("FAIL rmp_e1 got=%h want=e1", m_data); end
        tick();
        set_req(0, 1'b1, 8'hE2, 1'b0);
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0000 || m_valid !== 1'b0) begin bad++; $display("FAIL rmp_no_accept got=r%b v%b want=r0000 v0", req_ready, m_valid); end
        tick();
        total++; if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL rmp_state got=g%b b%b t%b want=g0000 b0 t0", gnt, busy, timeout); end
        total++; if (m_valid !== 1'b0 || m_data !== 8'h00 || req_ready !== 4'b0000) begin bad++; $display("FAIL rmp_outputs got=v%b d%h r%b want=v0 d00 r0000", m_valid, m_data, req_ready); end
        rst = 1'b0;
        set_req(0, 1'b1, 8'hE1, 1'b0);
        set_req(1, 1'b1, 8'hF1, 1'b1);
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rmp_priority got=%b want=0001", gnt); end
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        tick();
        rst = 1'b0;
        tick();
        $display("test_reset_mid_packet done");
    endtask

    task automatic test_random;
        int exp_seq [4];
        logic [3:0] acc;
        bit in_pkt = 1'b0;
        int cur_owner = 0;
        int src;
        bit all_done = 1'b0;
        rand_mode = 1'b1;
        model_init(6);
        for (int i = 0; i < 4; i++) exp_seq[i] = 0;
        for (int cyc = 0; cyc < 4000 && !all_done; cyc++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            drive_reqs();
            #1;
            acc = req_valid & req_ready;
            if (m_valid && m_ready) begin
                src = int'(m_data[7:6]);
                total++;
                if (m_data[5:0] !== 6'(exp_seq[src])) begin
                    bad++;
                    $display("FAIL rnd_order req%0d got=%0d want=%0d", src, m_data[5:0], exp_seq[src] & 63);
                end
                total++;
                if (acc !== (4'b0001 << src)) begin
                    bad++;
                    $display("FAIL rnd_accept got=%b want=%b", acc, 4'b0001 << src);
                end
                total++;
                if (in_pkt && src != cur_owner) begin
                    bad++;
                    $display("FAIL rnd_interleave got=req%0d want=req%0d", src, cur_owner);
                end
                exp_seq[src] = exp_seq[src] + 1;
                cur_owner = src;
                in_pkt = !req_last[src];
            end else begin
                total++;
                if (acc !== 4'b0000) begin
                    bad++;
                    $display("FAIL rnd_stray_accept got=%b want=0000", acc);
                end
            end
            tick();
            advance(acc);
            all_done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (pkts[i] != 0 || left[i] != 0) all_done = 1'b0;
            end
        end
        total++; if (!all_done) begin bad++; $display("FAIL rnd_budget got=unfinished want=finished"); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (exp_seq[i] !== gen_total[i]) begin
                bad++;
                $display("FAIL rnd_count req%0d got=%0d want=%0d", i, exp_seq[i], gen_total[i]);
            end
        end
        req_valid = '0;
        req_last = '0;
        $display("test_random done bytes=%0d/%0d/%0d/%0d", exp_seq[0], exp_seq[1], exp_seq[2], exp_seq[3]);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
